// File: rtl/shift_unit_seq_if.sv
// Operand, control and result bundle for shift_unit_seq.
// The master drives operands and start; the slave (the shifter) returns results.
interface shift_unit_seq_if #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [3:0]         alu_fun;
  logic [SHAMT_W-1:0] shamt;
  logic               shift_enable;
  logic [WIDTH-1:0]   shift_out;
  logic               shift_carry;
  logic               shift_flag;
  logic               busy;

  modport master (
    output a, b, alu_fun, shamt, shift_enable,
    input  shift_out, shift_carry, shift_flag, busy
  );

  modport slave (
    input  a, b, alu_fun, shamt, shift_enable,
    output shift_out, shift_carry, shift_flag, busy
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-position logical/arithmetic/rotate shifter, one position per cycle by default.
// Define SHIFT_UNIT_BARREL_EN for a single-cycle barrel variant (busy tied low, no FSM).
module shift_unit_seq #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input logic              clk,
  input logic              rst,
  shift_unit_seq_if.slave  bus
);

  // One-position step: returns {bit shifted out, shifted word}.
  function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] x,
                                          input logic             dir_left,
                                          input logic [1:0]       mode);
    logic [WIDTH-1:0] r;
    logic             c;
    c = dir_left ? x[WIDTH-1] : x[0];
    case (mode)
      2'b01:   r = dir_left ? {x[WIDTH-2:0], 1'b0} : {x[WIDTH-1], x[WIDTH-1:1]};
      2'b10:   r = dir_left ? {x[WIDTH-2:0], x[WIDTH-1]} : {x[0], x[WIDTH-1:1]};
      default: r = dir_left ? {x[WIDTH-2:0], 1'b0} : {1'b0, x[WIDTH-1:1]};
    endcase
    return {c, r};
  endfunction

  function automatic logic [SHAMT_W-1:0] clamp_amt(input logic [SHAMT_W-1:0] s);
    if (int'(s) >= WIDTH) begin
      return SHAMT_W'(WIDTH - 1);
    end else begin
      return s;
    end
  endfunction

  logic [SHAMT_W-1:0] amt_s;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               cout_q, cout_d;
  logic               flag_q, flag_d;

  assign amt_s           = clamp_amt(bus.shamt);
  assign bus.shift_out   = out_q;
  assign bus.shift_carry = cout_q;
  assign bus.shift_flag  = flag_q;

  // Result registers, held between operations.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q  <= {WIDTH{1'b0}};
      cout_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      cout_q <= cout_d;
      flag_q <= flag_d;
    end
  end

`ifdef SHIFT_UNIT_BARREL_EN

  logic [WIDTH-1:0] res_s;
  logic             res_c_s;

  // Barrel: chain of one-position steps, each gated by the clamped amount.
  always_comb begin
    logic [WIDTH:0] acc;
    logic [WIDTH:0] stp;
    acc = {1'b0, (bus.alu_fun[1] ? bus.b : bus.a)};
    stp = acc;
    for (int i = 0; i < WIDTH - 1; i++) begin
      stp = step(acc[WIDTH-1:0], bus.alu_fun[0], bus.alu_fun[3:2]);
      acc = (i < int'(amt_s)) ? stp : acc;
    end
    res_s   = acc[WIDTH-1:0];
    res_c_s = acc[WIDTH];
  end

  // Every request is accepted and completes on the next edge.
  always_comb begin
    if (bus.shift_enable) begin
      out_d  = res_s;
      cout_d = res_c_s;
    end else begin
      out_d  = out_q;
      cout_d = cout_q;
    end
    flag_d = bus.shift_enable;
  end

  assign bus.busy = 1'b0;

`else

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic [1:0]         mode_q, mode_d;
  logic               carry_q, carry_d;

  // FSM and datapath state; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      work_q  <= {WIDTH{1'b0}};
      cnt_q   <= {SHAMT_W{1'b0}};
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
    end
  end

  // Next-state and datapath; only the selected operand and control are latched.
  always_comb begin
    logic [WIDTH:0] stp;
    stp     = step(work_q, dir_q, mode_q);
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    out_d   = out_q;
    cout_d  = cout_q;
    flag_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.shift_enable) begin
          work_d  = bus.alu_fun[1] ? bus.b : bus.a;
          dir_d   = bus.alu_fun[0];
          mode_d  = bus.alu_fun[3:2];
          cnt_d   = amt_s;
          carry_d = 1'b0;
          state_d = (amt_s != {SHAMT_W{1'b0}}) ? SHIFT : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d  = stp[WIDTH-1:0];
        carry_d = stp[WIDTH];
        cnt_d   = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        out_d   = work_q;
        cout_d  = carry_q;
        flag_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q != IDLE);

`endif

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed, table-driven bench for shift_unit_seq (iterative or barrel build).
`timescale 1ns/1ps
module tb_shift_unit_seq;
  localparam int W  = 16;
  localparam int SW = 4;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  fun;
    logic [3:0]  shamt;
    logic [15:0] exp_out;
    logic        exp_c;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_unit_seq_if #(.WIDTH(W), .SHAMT_W(SW)) bus();
  shift_unit_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int exp_lat(input logic [3:0] sh);
`ifdef SHIFT_UNIT_BARREL_EN
    return 1;
`else
    return int'(sh) + 2;
`endif
  endfunction

  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] fun, input logic [3:0] sh);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.alu_fun = fun; bus.shamt = sh;
    bus.shift_enable = 1'b1;
    @(posedge clk); #1;
    bus.shift_enable = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    int busy_bad;
    lat = 0;
    busy_bad = 0;
    start_op(v.a, v.b, v.fun, v.shamt);
    // Scramble inputs: the operation must use only what was latched at start.
    bus.a = ~v.a; bus.b = ~v.b; bus.alu_fun = ~v.fun; bus.shamt = ~v.shamt;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (bus.shift_flag === 1'b1) begin
        lat = c;
        if (bus.busy !== 1'b0) busy_bad++;
        break;
      end
`ifdef SHIFT_UNIT_BARREL_EN
      if (bus.busy !== 1'b0) busy_bad++;
`else
      if (bus.busy !== 1'b1) busy_bad++;
`endif
    end
    chk({nm, "_lat"},   lat,              exp_lat(v.shamt));
    chk({nm, "_out"},   bus.shift_out,    v.exp_out);
    chk({nm, "_carry"}, bus.shift_carry,  v.exp_c);
    chk({nm, "_busy"},  busy_bad,         0);
    @(posedge clk); #1;
    chk({nm, "_pulse"}, bus.shift_flag,   1'b0);
  endtask

  initial begin
    int flags;
    int first_c;
    int last_c;
    int busy_bad;
    logic [15:0] last_out;
    logic        last_c_bit;

    vecs[0]  = '{16'h8001, 16'h0000, 4'b0000, 4'd3,  16'h1000, 1'b0};
    vecs[1]  = '{16'h1234, 16'hF000, 4'b0110, 4'd4,  16'hFF00, 1'b0};
    vecs[2]  = '{16'h1234, 16'hF00F, 4'b0110, 4'd4,  16'hFF00, 1'b1};
    vecs[3]  = '{16'h8001, 16'h0000, 4'b1001, 4'd1,  16'h0003, 1'b1};
    vecs[4]  = '{16'h8001, 16'h0000, 4'b1001, 4'd0,  16'h8001, 1'b0};
    vecs[5]  = '{16'h0001, 16'h0000, 4'b0001, 4'd15, 16'h8000, 1'b0};
    vecs[6]  = '{16'h0001, 16'h0000, 4'b1000, 4'd1,  16'h8000, 1'b1};
    vecs[7]  = '{16'hC003, 16'h0000, 4'b0101, 4'd2,  16'h000C, 1'b1};
    vecs[8]  = '{16'h00F0, 16'h0000, 4'b1100, 4'd5,  16'h0007, 1'b1};
    vecs[9]  = '{16'h4000, 16'h0000, 4'b0100, 4'd14, 16'h0001, 1'b0};
    vecs[10] = '{16'h0000, 16'h0F0F, 4'b0011, 4'd5,  16'hE1E0, 1'b1};
    vecs[11] = '{16'h0000, 16'h1234, 4'b1010, 4'd6,  16'hD048, 1'b1};
    vecs[12] = '{16'hFFFF, 16'h0000, 4'b0000, 4'd0,  16'hFFFF, 1'b0};

    bus.a = 16'h0000; bus.b = 16'h0000; bus.alu_fun = 4'b0000;
    bus.shamt = 4'd0; bus.shift_enable = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out",   bus.shift_out,   16'h0000);
    chk("rst_carry", bus.shift_carry, 1'b0);
    chk("rst_flag",  bus.shift_flag,  1'b0);
    chk("rst_busy",  bus.busy,        1'b0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end
    run_vec(vecs[11], "vec11b");

    // Asynchronous reset in the middle of a long shift.
    start_op(16'hFFFF, 16'h0000, 4'b0000, 4'd8);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_out",   bus.shift_out,   16'h0000);
    chk("midrst_carry", bus.shift_carry, 1'b0);
    chk("midrst_flag",  bus.shift_flag,  1'b0);
    chk("midrst_busy",  bus.busy,        1'b0);
    @(negedge clk);
    rst = 1'b1;
    flags = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.shift_flag === 1'b1) flags++;
    end
    chk("midrst_noflag", flags, 0);
    run_vec(vecs[0], "postrst");

    // A second request while busy must be ignored.
    start_op(16'h0001, 16'h0000, 4'b0001, 4'd15);
    flags = 0; first_c = 0;
    last_out = 16'h0000; last_c_bit = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (bus.shift_flag === 1'b1) begin
        flags++;
        if (first_c == 0) first_c = c;
        last_out = bus.shift_out;
        last_c_bit = bus.shift_carry;
      end
      if (c == 5) begin
        bus.a = 16'hFFFF; bus.alu_fun = 4'b0000; bus.shamt = 4'd1;
        bus.shift_enable = 1'b1;
      end
      if (c == 6) bus.shift_enable = 1'b0;
    end
`ifdef SHIFT_UNIT_BARREL_EN
    chk("ign_flags", flags,      2);
    chk("ign_first", first_c,    1);
    chk("ign_out",   last_out,   16'h7FFF);
    chk("ign_carry", last_c_bit, 1'b1);
`else
    chk("ign_flags", flags,      1);
    chk("ign_first", first_c,    17);
    chk("ign_out",   last_out,   16'h8000);
    chk("ign_carry", last_c_bit, 1'b0);
`endif

    // Back-to-back operations with shift_enable held high.
    @(negedge clk);
    bus.a = 16'h8001; bus.b = 16'h0000; bus.alu_fun = 4'b0000; bus.shamt = 4'd2;
    bus.shift_enable = 1'b1;
    flags = 0; first_c = 0; last_c = 0; busy_bad = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus.shift_flag === 1'b1) begin
        flags++;
        if (first_c == 0) first_c = c;
        last_c = c;
        chk("b2b_out", bus.shift_out, 16'h2000);
      end
`ifdef SHIFT_UNIT_BARREL_EN
      if (bus.busy !== 1'b0) busy_bad++;
`endif
    end
    bus.shift_enable = 1'b0;
`ifdef SHIFT_UNIT_BARREL_EN
    chk("b2b_flags", flags,   20);
    chk("b2b_first", first_c, 1);
`else
    chk("b2b_flags", flags,   5);
    chk("b2b_first", first_c, 4);
`endif
    chk("b2b_last",  last_c,   20);
    chk("b2b_busy",  busy_bad, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
